// File: rtl/adc_capture_pkg.sv
// -----------------------------------------------------------------------------
// adc_capture_pkg
// Shared definitions for the ADC trigger/capture block:
//   - cap_state_e : capture controller states (IDLE, ACK, CAPTURE, DONE)
//   - DEF_*       : default sample width, channel count and RAM address width
//   - clamp_len() : limits a requested record length to the RAM depth
// -----------------------------------------------------------------------------
package adc_capture_pkg;

   localparam int DEF_DATA_W = 12;
   localparam int DEF_NCH    = 8;
   localparam int DEF_ADDR_W = 14;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACK     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } cap_state_e;

   // Returns min(rec_len, 2^addr_w): a record can never exceed the RAM depth,
   // which also guarantees the write address never wraps.
   function automatic logic [31:0] clamp_len(input logic [31:0] rec_len,
                                             input int          addr_w);
      logic [31:0] max_len;
      max_len = 32'd1 << addr_w;
      return (rec_len > max_len) ? max_len : rec_len;
   endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// -----------------------------------------------------------------------------
// edge_detect_rise
// Registered rising-edge detector for a level trigger input.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   sig_i  : level input (already synchronous to clk)
//   rise_o : high for the cycle in which sig_i is 1 and its registered
//            previous value is 0
// A level that is already high when reset releases is not reported as an
// edge: detection is armed only after the first clock out of reset has
// loaded the previous-value register.
// -----------------------------------------------------------------------------
module edge_detect_rise (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic rise_o
);

   logic prev_q;
   logic armed_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         prev_q  <= sig_i;
         armed_q <= 1'b1;
      end
   end

   assign rise_o = armed_q & sig_i & ~prev_q;

endmodule

// File: rtl/adc_trig_capture.sv
// -----------------------------------------------------------------------------
// adc_trig_capture
// Accepts a receive trigger, returns the acknowledge handshake to the trigger
// stage, then writes a programmed number of ADC sample words into the sample
// RAM and reports completion/status to the host.
//
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   adcTrig      : level trigger from the trigger stage, held until acked
//   adcAckLine   : acknowledge back to the trigger stage
//   recLength    : words to capture, sampled at the trigger (clamped to depth)
//   adcData      : NCH packed samples, channel 0 in the LSBs
//   adcDataValid : adcData valid this cycle
//   clearDone    : host pulse clearing captureDone / trigOverrun
//   memWrEn      : RAM write strobe (registered, 1 cycle after valid)
//   memWrAddr    : RAM write address
//   memWrData    : RAM write data
//   busy         : high in ACK and CAPTURE
//   captureDone  : sticky completion flag, high in DONE
//   trigOverrun  : sticky, trigger edge seen outside IDLE
//   decim        : (CAPTURE_DECIM_EN only) write every (decim+1)-th sample
//
// Build option: define CAPTURE_DECIM_EN to add the decim input and sample
// decimation during capture. Without it every valid sample is written.
// -----------------------------------------------------------------------------
module adc_trig_capture
   import adc_capture_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NCH    = DEF_NCH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  adcTrig,
   output logic                  adcAckLine,
   input  logic [ADDR_W:0]       recLength,
   input  logic [NCH*DATA_W-1:0] adcData,
   input  logic                  adcDataValid,
   input  logic                  clearDone,
`ifdef CAPTURE_DECIM_EN
   input  logic [3:0]            decim,
`endif
   output logic                  memWrEn,
   output logic [ADDR_W-1:0]     memWrAddr,
   output logic [NCH*DATA_W-1:0] memWrData,
   output logic                  busy,
   output logic                  captureDone,
   output logic                  trigOverrun
);

   cap_state_e            state_q;
   logic                  ack_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  ovr_q;
   logic                  wr_en_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [NCH*DATA_W-1:0] data_q;
   logic [ADDR_W:0]       count_q;
   logic [ADDR_W:0]       len_q;

   logic                  trig_rise;
   logic [ADDR_W:0]       len_clamped;
   logic [ADDR_W:0]       count_inc;
   logic                  take_sample;

   edge_detect_rise u_trig_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (adcTrig),
      .rise_o (trig_rise)
   );

   assign len_clamped = (ADDR_W+1)'(clamp_len(32'(recLength), ADDR_W));
   assign count_inc   = count_q + 1'b1;

`ifdef CAPTURE_DECIM_EN
   logic [3:0] decim_q;
   logic [3:0] phase_q;

   // phase_q counts valid samples modulo (decim+1); only phase 0 is stored,
   // so the first valid sample after entering CAPTURE is always written.
   assign take_sample = adcDataValid && (phase_q == 4'd0);
`else
   assign take_sample = adcDataValid;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         count_q <= '0;
         len_q   <= '0;
`ifdef CAPTURE_DECIM_EN
         decim_q <= '0;
         phase_q <= '0;
`endif
      end else begin
         wr_en_q <= 1'b0;

         // Set beats clear: an edge arriving with clearDone leaves the flag set.
         if (trig_rise && (state_q != ST_IDLE)) begin
            ovr_q <= 1'b1;
         end else if (clearDone) begin
            ovr_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (trig_rise) begin
                  state_q <= ST_ACK;
                  ack_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  len_q   <= len_clamped;
                  count_q <= '0;
                  addr_q  <= '0;
`ifdef CAPTURE_DECIM_EN
                  decim_q <= decim;
                  phase_q <= '0;
`endif
               end
            end

            ST_ACK: begin
               // Ack stays up as long as the trigger stage holds adcTrig.
               if (!adcTrig) begin
                  ack_q <= 1'b0;
                  if (len_q != '0) begin
                     state_q <= ST_CAPTURE;
                  end else begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end

            ST_CAPTURE: begin
`ifdef CAPTURE_DECIM_EN
               if (adcDataValid) begin
                  phase_q <= (phase_q == decim_q) ? 4'd0 : phase_q + 4'd1;
               end
`endif
               if (take_sample) begin
                  wr_en_q <= 1'b1;
                  addr_q  <= count_q[ADDR_W-1:0];
                  data_q  <= adcData;
                  count_q <= count_inc;
                  if (count_inc == len_q) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end

            ST_DONE: begin
               if (clearDone) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign adcAckLine  = ack_q;
   assign busy        = busy_q;
   assign captureDone = done_q;
   assign trigOverrun = ovr_q;
   assign memWrEn     = wr_en_q;
   assign memWrAddr   = addr_q;
   assign memWrData   = data_q;

endmodule

// File: tb/tb_adc_trig_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_trig_capture
// Scoreboarded bench: each capture pushes the expected RAM writes (address,
// data, cycle) as the samples are issued; an independent monitor pops and
// compares whenever memWrEn is seen. Flag behaviour is checked inline.
// -----------------------------------------------------------------------------
module tb_adc_trig_capture;

   localparam int DATA_W = 12;
   localparam int NCH    = 8;
   localparam int ADDR_W = 14;
   localparam int DW     = NCH * DATA_W;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DW-1:0]     data;
      int                cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              adcTrig = 1'b0;
   logic              adcAckLine;
   logic [ADDR_W:0]   recLength = '0;
   logic [DW-1:0]     adcData = '0;
   logic              adcDataValid = 1'b0;
   logic              clearDone = 1'b0;
   logic [3:0]        decim_v = 4'd0;
   logic              memWrEn;
   logic [ADDR_W-1:0] memWrAddr;
   logic [DW-1:0]     memWrData;
   logic              busy;
   logic              captureDone;
   logic              trigOverrun;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   exp_ovr  = 1'b0;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adc_trig_capture #(
      .DATA_W (DATA_W),
      .NCH    (NCH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .adcTrig      (adcTrig),
      .adcAckLine   (adcAckLine),
      .recLength    (recLength),
      .adcData      (adcData),
      .adcDataValid (adcDataValid),
      .clearDone    (clearDone),
`ifdef CAPTURE_DECIM_EN
      .decim        (decim_v),
`endif
      .memWrEn      (memWrEn),
      .memWrAddr    (memWrAddr),
      .memWrData    (memWrData),
      .busy         (busy),
      .captureDone  (captureDone),
      .trigOverrun  (trigOverrun)
   );

   task automatic check_bit(input string name, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b required %b (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_val(input string name, input logic [127:0] act,
                            input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      return DW'({$urandom, $urandom, $urandom});
   endfunction

   // Monitor: every observed write must match the oldest expected write.
   initial begin
      forever begin
         @(negedge clk);
         if (memWrEn === 1'b1) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got write to addr %0d, required no write", memWrAddr);
            end else begin
               mon_e = sb.pop_front();
               check_val("wr_addr",  128'(memWrAddr), 128'(mon_e.addr));
               check_val("wr_data",  128'(memWrData), 128'(mon_e.data));
               check_val("wr_cycle", 128'(cyc),       128'(mon_e.cyc));
            end
         end
      end
   end

   // One full capture: trigger handshake, sample stream, DONE checks.
   // Reference rule: the k-th valid sample after CAPTURE entry is stored when
   // k is a multiple of (dec+1), until min(rec, DEPTH) words have been stored.
   task automatic run_capture(input int rec, input int dec, input bit gaps,
                              input bit ovr_mid, input int extra);
      int len;
      int k;
      int written;
      int h;
      bit pulsed;
      logic [DW-1:0] d;
      exp_t e;

      repeat (2) @(posedge clk);
      #1;
      recLength = (ADDR_W+1)'(rec);
      decim_v   = 4'(dec);
      adcTrig   = 1'b1;
      len       = (rec > DEPTH) ? DEPTH : rec;
      h         = $urandom_range(1, 4);
      repeat (h) begin
         @(posedge clk);
         #1;
         check_bit("ack_high", adcAckLine, 1'b1);
         check_bit("busy_in_ack", busy, 1'b1);
      end
      // Length and decimation are latched at the trigger; disturb the inputs.
      recLength = (ADDR_W+1)'($urandom);
      decim_v   = 4'($urandom);
      adcTrig   = 1'b0;
      @(posedge clk);
      #1;
      check_bit("ack_low", adcAckLine, 1'b0);
      if (len == 0) begin
         check_bit("busy_zero_len", busy, 1'b0);
         check_bit("done_zero_len", captureDone, 1'b1);
      end else begin
         check_bit("busy_capture", busy, 1'b1);
      end

      k = 0;
      written = 0;
      pulsed = 1'b0;
      while (written < len) begin
         adcTrig = 1'b0;
         if (ovr_mid && !pulsed && written == 1) begin
            adcTrig = 1'b1;
            pulsed  = 1'b1;
            exp_ovr = 1'b1;
         end
         d = rand_word();
         adcData = d;
         if (!gaps || $urandom_range(0, 2) != 0) begin
            adcDataValid = 1'b1;
            if (k % (dec + 1) == 0) begin
               e.addr = ADDR_W'(written);
               e.data = d;
               e.cyc  = cyc + 1;
               sb.push_back(e);
               written++;
            end
            k++;
         end else begin
            adcDataValid = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      adcTrig = 1'b0;
      check_bit("done_set", captureDone, 1'b1);
      check_bit("busy_done", busy, 1'b0);

      repeat (extra) begin
         adcData = rand_word();
         adcDataValid = 1'b1;
         @(posedge clk);
         #1;
      end
      adcDataValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check_val("sb_drained", 128'(sb.size()), 128'(0));
      check_bit("done_held", captureDone, 1'b1);
      check_bit("overrun_flag", trigOverrun, exp_ovr);
      check_bit("ack_idle", adcAckLine, 1'b0);
      $display("capture rec=%0d dec=%0d gaps=%0d stored=%0d", rec, dec, gaps, written);
   endtask

   // Host clear; optionally with a simultaneous trigger edge, which is lost
   // but still marks an overrun.
   task automatic clear_done(input bit with_edge);
      @(posedge clk);
      #1;
      clearDone = 1'b1;
      if (with_edge) adcTrig = 1'b1;
      @(posedge clk);
      #1;
      clearDone = 1'b0;
      exp_ovr = with_edge;
      check_bit("clear_done", captureDone, 1'b0);
      check_bit("clear_overrun", trigOverrun, exp_ovr);
      if (with_edge) begin
         repeat (3) begin
            @(posedge clk);
            #1;
            check_bit("edge_lost_busy", busy, 1'b0);
         end
         adcTrig = 1'b0;
      end
      $display("clear with_edge=%0d overrun=%0b", with_edge, trigOverrun);
   endtask

   initial begin
      int dec;

      // Reset with the trigger already high: no capture must start from it.
      rst = 1'b0;
      adcTrig = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_bit("rst_wren", memWrEn, 1'b0);
      check_bit("rst_ack", adcAckLine, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_done", captureDone, 1'b0);
      check_bit("rst_ovr", trigOverrun, 1'b0);
      check_val("rst_addr", 128'(memWrAddr), 128'(0));
      @(negedge clk);
      rst = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         check_bit("held_trig_no_accept", busy, 1'b0);
      end
      adcTrig = 1'b0;
      $display("reset checks done");

      // Basic capture: 4 words from a stream of 10 valid samples.
      run_capture(4, 0, 1'b0, 1'b0, 6);
      clear_done(1'b0);

      // Zero-length record goes straight from ACK to DONE.
      run_capture(0, 0, 1'b0, 1'b0, 3);
      clear_done(1'b0);

      // Trigger edge during CAPTURE, then clear racing a new edge in DONE.
      run_capture(8, 0, 1'b1, 1'b1, 2);
      clear_done(1'b1);
      run_capture(5, 0, 1'b1, 1'b0, 2);
      clear_done(1'b0);

`ifdef CAPTURE_DECIM_EN
      // decim = 2 over 9 valid samples stores S0, S3, S6.
      run_capture(3, 2, 1'b0, 1'b0, 2);
      clear_done(1'b0);
`endif

      // Randomized records.
      for (int i = 0; i < 8; i++) begin
`ifdef CAPTURE_DECIM_EN
         dec = $urandom_range(0, 3);
`else
         dec = 0;
`endif
         run_capture($urandom_range(1, 40), dec, 1'b1, 1'b0, $urandom_range(0, 4));
         clear_done(1'b0);
      end

      // Oversized request is clamped to the RAM depth; no address wrap.
      run_capture(DEPTH + 5, 0, 1'b0, 1'b0, 4);
      clear_done(1'b0);

      // Asynchronous reset after 3 of 8 writes.
      @(posedge clk);
      #1;
      recLength = (ADDR_W+1)'(8);
      adcTrig = 1'b1;
      @(posedge clk);
      #1;
      adcTrig = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         mon_e.addr = ADDR_W'(i);
         mon_e.data = rand_word();
         mon_e.cyc  = cyc + 1;
         sb.push_back(mon_e);
         adcData = mon_e.data;
         adcDataValid = 1'b1;
         @(posedge clk);
         #1;
      end
      adcData = rand_word();
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_bit("async_rst_wren", memWrEn, 1'b0);
      check_bit("async_rst_busy", busy, 1'b0);
      check_bit("async_rst_done", captureDone, 1'b0);
      check_bit("async_rst_ack", adcAckLine, 1'b0);
      adcDataValid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1;
      exp_ovr = 1'b0;
      check_val("sb_after_rst", 128'(sb.size()), 128'(0));
      $display("async reset mid-capture done");
      run_capture(3, 0, 1'b0, 1'b0, 2);
      clear_done(1'b0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_trig_capture.md
Name: adc_trig_capture

Overview:
- Downstream consumer of the receive system-trigger stage.
- Detects the receive trigger (outputTrig) and returns the acknowledge (adcAckLine) that lets the trigger stage finish.
- Then captures a programmed number of ADC sample words into the sample RAM through a simple write port, and reports completion and status to the host.

Parameters:
- DATA_W, 12, bits per ADC channel sample
- NCH, 8, channels packed per sample word
- ADDR_W, 14, sample RAM address width; max record = 2^ADDR_W words

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- adcTrig  in  1  receive trigger from the trigger stage; level, held until acknowledged
- adcAckLine  out  1  acknowledge to the trigger stage
- recLength  in  ADDR_W+1  sample words to capture; sampled at the trigger
- adcData  in  NCH*DATA_W  packed ADC samples; ch0 in LSBs
- adcDataValid  in  1  adcData valid this cycle
- clearDone  in  1  host pulse; clears captureDone and trigOverrun
- memWrEn  out  1  RAM write strobe
- memWrAddr  out  ADDR_W  RAM write address
- memWrData  out  NCH*DATA_W  RAM write data
- busy  out  1  high from trigger accept until DONE
- captureDone  out  1  sticky completion flag
- trigOverrun  out  1  sticky; a trigger rising edge arrived while not IDLE

Behaviour:
- Reset (rst low, async):
  - State = IDLE.
  - All outputs 0; address and count 0; trigger edge-detect register 0.
  - Reset mid-capture aborts with no further writes. captureDone is not set.
- States: IDLE, ACK, CAPTURE, DONE.
- IDLE:
  - A rising edge of adcTrig (registered previous value 0, current 1) latches len = min(recLength, 2^ADDR_W), clears address and count, and moves to ACK.
  - adcTrig already high out of reset does not trigger; an edge is required.
- ACK:
  - adcAckLine = 1 for at least one cycle, held while adcTrig = 1.
  - When adcTrig = 0: adcAckLine -> 0 next cycle. Then go to CAPTURE if len != 0, otherwise go directly to DONE.
- CAPTURE:
  - Each cycle with adcDataValid = 1 registers memWrEn = 1, memWrAddr = count[ADDR_W-1:0] and memWrData = adcData. Latency is exactly 1 cycle.
  - Count increments on each write. After write number len, go to DONE in the same edge.
  - No write occurs for adcDataValid during IDLE, ACK or DONE.
  - The address never wraps: len <= 2^ADDR_W, so the final address is len-1.
- DONE:
  - captureDone = 1 and busy = 0.
  - Remains in DONE until clearDone, then goes to IDLE.
  - A trigger edge in DONE is not accepted.
- busy = 1 in ACK and CAPTURE.
- trigOverrun is set on any adcTrig rising edge seen outside IDLE.
- clearDone:
  - Clears trigOverrun in any state.
  - clearDone together with a trigger edge in DONE: clear wins, go to IDLE; that edge is lost and trigOverrun stays set (set beats clear).
- Simultaneous last write and clearDone: the write completes, DONE is entered, and clearDone is ignored because it only acts in DONE.

Optional Feature:
- Macro: CAPTURE_DECIM_EN
- Defined:
  - Adds input decim [3:0].
  - decim is latched at the trigger along with recLength.
  - In CAPTURE, only every (decim+1)-th valid sample is written; the first valid sample after entering CAPTURE is always written.
  - len counts written words, not input samples.
  - decim = 0 is identical to the undefined build.
- Undefined: every valid sample is written; no decim port.

Decomposition:
- Shared package adc_capture_pkg holds:
  - state enum (IDLE, ACK, CAPTURE, DONE)
  - default DATA_W / NCH / ADDR_W constants
  - function clamp_len(recLength) returning the clamped length
- One natural sub-module, edge_detect_rise: registered rising-edge detector for adcTrig, reusable for the other trigger inputs.

Test Plan:
- recLength = 4, adcTrig pulse, 10 consecutive valid samples D0..D9 -> adcAckLine high until adcTrig low. Writes D0..D3 to addresses 0..3, each 1 cycle after valid. captureDone = 1, no further memWrEn.
- recLength = 0 -> ack handshake completes, then captureDone with no memWrEn and busy low after ACK.
- recLength = 2^ADDR_W + 5 -> exactly 16384 writes, last address 16383, no wrap to 0.
- Second adcTrig edge during CAPTURE -> trigOverrun = 1, capture unaffected. clearDone in DONE -> flags clear, IDLE, next edge accepted.
- rst low after 3 of 8 writes -> memWrEn 0 immediately (async). After reset: IDLE, captureDone = 0, next trigger restarts at address 0.
- CAPTURE_DECIM_EN, decim = 2, recLength = 3, valid samples S0..S8 -> writes S0, S3, S6 to addresses 0..2.
